// File: rtl/axi_rd_pkg.sv
// Shared definitions for the AXI4 memory-mapped read responder.
// Contents:
//   RESP_*         AXI read response codes
//   BURST_*        supported burst encodings
//   SIZE_64B       the only legal arsize (64-byte beats)
//   ar_req_t       one queued read-address request
//   r_beat_t       one read-data beat waiting in the output buffer
//   req_is_illegal whole-burst SLVERR condition
package axi_rd_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [2:0] SIZE_64B = 3'b110;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_req_t;

  typedef struct packed {
    logic [3:0]   id;
    logic [511:0] data;
    logic [1:0]   resp;
    logic         last;
  } r_beat_t;

  // Unsupported beat size or a reserved/WRAP burst type fails the whole burst.
  function automatic logic req_is_illegal(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_64B) || (burst == 2'b10) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/axi_ar_fifo.sv
// Synchronous FIFO holding accepted AR requests until the burst engine takes them.
// Ports:
//   axis_clk, axis_rst   clock and synchronous active-high reset
//   push, push_req       write side; ignored while full
//   full                 registered full flag (drives arready upstream)
//   pop                  read side; ignored while empty
//   pop_req              head entry (valid whenever empty is low)
//   empty                registered empty flag
module axi_ar_fifo
  import axi_rd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    axis_clk,
  input  logic    axis_rst,
  input  logic    push,
  input  ar_req_t push_req,
  output logic    full,
  input  logic    pop,
  output ar_req_t pop_req,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);

  ar_req_t       store_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != (PW+1)'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (do_push) store_q[wr_ptr_q] <= push_req;
  end

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_req = store_q[rd_ptr_q];

endmodule

// File: rtl/axi_mm_read_responder.sv
// AXI4 read slave backed by a 512-bit-wide on-chip memory with a backdoor preload port.
// Ports:
//   axis_clk, axis_rst           clock, synchronous active-high reset
//   s_axi_ar*                    read-address channel (queued in axi_ar_fifo)
//   s_axi_r*                     read-data channel, one beat per cycle when rready is high
//   mem_wr_en/addr/data          backdoor word write (read-first against engine reads)
//   busy                         queue, engine, read pipe or output buffer occupied
//   burst_cnt                    completed bursts (rlast handshakes), wraps at 2^32
// Datapath: AR FIFO -> burst engine (one memory read per cycle) -> 1-cycle memory
// read register -> 2-entry output buffer -> R channel.
module axi_mm_read_responder
  import axi_rd_pkg::*;
#(
  parameter int DEPTH_WORDS   = 1024,
  parameter int AR_FIFO_DEPTH = 4
) (
  input  logic                           axis_clk,
  input  logic                           axis_rst,
  input  logic [3:0]                     s_axi_arid,
  input  logic [63:0]                    s_axi_araddr,
  input  logic [7:0]                     s_axi_arlen,
  input  logic [2:0]                     s_axi_arsize,
  input  logic [1:0]                     s_axi_arburst,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [3:0]                     s_axi_rid,
  output logic [511:0]                   s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rlast,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  input  logic                           mem_wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] mem_wr_addr,
  input  logic [511:0]                   mem_wr_data,
  output logic                           busy,
  output logic [31:0]                    burst_cnt
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // ---------------- AR queue ----------------
  ar_req_t ar_req, fifo_req;
  logic    fifo_full, fifo_empty, fifo_pop;
  logic [5:0] unused_addr_lsbs;

  assign ar_req = '{id: s_axi_arid, addr: s_axi_araddr, len: s_axi_arlen,
                    size: s_axi_arsize, burst: s_axi_arburst};
  assign s_axi_arready = !fifo_full && !axis_rst;
  // Byte offset inside a word is ignored: reads always return the aligned word.
  assign unused_addr_lsbs = fifo_req.addr[5:0];

  axi_ar_fifo #(.DEPTH(AR_FIFO_DEPTH)) u_ar_fifo (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .push     (s_axi_arvalid && s_axi_arready),
    .push_req (ar_req),
    .full     (fifo_full),
    .pop      (fifo_pop),
    .pop_req  (fifo_req),
    .empty    (fifo_empty)
  );

  // ---------------- engine, read pipe and output buffer state ----------------
  logic [0:0]  state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [58:0] idx_q, idx_d;   // one spare bit so INCR past the top never wraps
  logic [7:0]  len_q, len_d;
  logic [7:0]  beat_q, beat_d;
  logic        illegal_q, illegal_d;
  logic        fixed_q, fixed_d;

  logic        pipe_v_q, pipe_v_d;
  logic [3:0]  pipe_id_q, pipe_id_d;
  logic [1:0]  pipe_resp_q, pipe_resp_d;
  logic        pipe_last_q, pipe_last_d;
  logic [511:0] mem_rdata_q;

  r_beat_t     obuf_q [2];
  r_beat_t     obuf_d [2];
  logic        owr_q, owr_d, ord_q, ord_d;
  logic [1:0]  ocnt_q, ocnt_d;
  logic [31:0] burst_cnt_q, burst_cnt_d;

  logic        r_pop, issue;
  logic [1:0]  issue_resp;
  r_beat_t     pipe_beat, head_beat;

  logic [511:0] mem [DEPTH_WORDS];

  always_comb begin
    r_pop       = (ocnt_q != 2'd0) && s_axi_rready;
    state_d     = state_q;
    id_d        = id_q;
    idx_d       = idx_q;
    len_d       = len_q;
    beat_d      = beat_q;
    illegal_d   = illegal_q;
    fixed_d     = fixed_q;
    fifo_pop    = 1'b0;
    issue       = 1'b0;
    issue_resp  = RESP_OKAY;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          id_d      = fifo_req.id;
          idx_d     = {1'b0, fifo_req.addr[63:6]};
          len_d     = fifo_req.len;
          beat_d    = 8'd0;
          illegal_d = req_is_illegal(fifo_req.size, fifo_req.burst);
          fixed_d   = (fifo_req.burst == BURST_FIXED);
          state_d   = ST_BURST;
        end
      end
      default: begin
        // Beats in flight (buffered + in the read register) may not exceed the
        // 2 buffer slots; counting this cycle's pop keeps streaming at full rate.
        if (({1'b0, ocnt_q} + {2'b0, pipe_v_q}) <= (3'd1 + {2'b0, r_pop})) begin
          issue = 1'b1;
          if (illegal_q)
            issue_resp = RESP_SLVERR;
          else if (idx_q >= 59'(DEPTH_WORDS))
            issue_resp = RESP_DECERR;
          if (beat_q == len_q) begin
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
            if (!fixed_q) idx_d = idx_q + 59'd1;
          end
        end
      end
    endcase

    pipe_v_d    = issue;
    pipe_id_d   = id_q;
    pipe_resp_d = issue_resp;
    pipe_last_d = (beat_q == len_q);

    // Error beats carry zero data regardless of what the memory returned.
    pipe_beat = '{id: pipe_id_q,
                  data: (pipe_resp_q == RESP_OKAY) ? mem_rdata_q : 512'd0,
                  resp: pipe_resp_q, last: pipe_last_q};

    obuf_d = obuf_q;
    owr_d  = owr_q;
    ord_d  = ord_q;
    if (pipe_v_q) begin
      obuf_d[owr_q] = pipe_beat;
      owr_d         = ~owr_q;
    end
    if (r_pop) ord_d = ~ord_q;
    ocnt_d = ocnt_q + {1'b0, pipe_v_q} - {1'b0, r_pop};

    burst_cnt_d = burst_cnt_q + 32'(r_pop && obuf_q[ord_q].last);
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      illegal_q   <= 1'b0;
      fixed_q     <= 1'b0;
      pipe_v_q    <= 1'b0;
      pipe_id_q   <= '0;
      pipe_resp_q <= '0;
      pipe_last_q <= 1'b0;
      owr_q       <= 1'b0;
      ord_q       <= 1'b0;
      ocnt_q      <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      illegal_q   <= illegal_d;
      fixed_q     <= fixed_d;
      pipe_v_q    <= pipe_v_d;
      pipe_id_q   <= pipe_id_d;
      pipe_resp_q <= pipe_resp_d;
      pipe_last_q <= pipe_last_d;
      owr_q       <= owr_d;
      ord_q       <= ord_d;
      ocnt_q      <= ocnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Buffer payload needs no reset: the R outputs are masked while rvalid is low.
  always_ff @(posedge axis_clk) begin
    obuf_q <= obuf_d;
  end

  // Block RAM: nonblocking write/read on the same edge gives read-first behaviour.
  // Out-of-range indices read an aliased word whose data is discarded as DECERR.
  always_ff @(posedge axis_clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (issue) mem_rdata_q <= mem[idx_q[AW-1:0]];
  end

  // ---------------- outputs ----------------
  assign head_beat    = obuf_q[ord_q];
  assign s_axi_rvalid = (ocnt_q != 2'd0);
  assign s_axi_rid    = s_axi_rvalid ? head_beat.id   : 4'd0;
  assign s_axi_rdata  = s_axi_rvalid ? head_beat.data : 512'd0;
  assign s_axi_rresp  = s_axi_rvalid ? head_beat.resp : 2'd0;
  assign s_axi_rlast  = s_axi_rvalid && head_beat.last;
  assign busy         = !fifo_empty || (state_q == ST_BURST) || pipe_v_q || s_axi_rvalid;
  assign burst_cnt    = burst_cnt_q;

endmodule

// File: tb/tb_axi_mm_read_responder.sv
// Self-checking bench for axi_mm_read_responder. Expected beats are computed from
// the AXI read rules (word index, burst type, size/burst legality, range) against a
// bench-side copy of memory, queued at AR acceptance, and compared by an R monitor.
module tb_axi_mm_read_responder;

  localparam int DEPTH_WORDS   = 1024;
  localparam int AR_FIFO_DEPTH = 4;

  logic         axis_clk = 1'b0;
  logic         axis_rst = 1'b1;
  logic [3:0]   s_axi_arid = '0;
  logic [63:0]  s_axi_araddr = '0;
  logic [7:0]   s_axi_arlen = '0;
  logic [2:0]   s_axi_arsize = 3'b110;
  logic [1:0]   s_axi_arburst = 2'b01;
  logic         s_axi_arvalid = 1'b0;
  logic         s_axi_arready;
  logic [3:0]   s_axi_rid;
  logic [511:0] s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rlast;
  logic         s_axi_rvalid;
  logic         s_axi_rready = 1'b0;
  logic         mem_wr_en = 1'b0;
  logic [9:0]   mem_wr_addr = '0;
  logic [511:0] mem_wr_data = '0;
  logic         busy;
  logic [31:0]  burst_cnt;

  axi_mm_read_responder #(.DEPTH_WORDS(DEPTH_WORDS), .AR_FIFO_DEPTH(AR_FIFO_DEPTH)) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .burst_cnt(burst_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct {
    logic [3:0]   id;
    logic [511:0] data;
    logic [1:0]   resp;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  logic [511:0] ref_mem [DEPTH_WORDS];
  int           checks = 0;
  int           errors = 0;
  int           exp_bursts = 0;
  int           rready_mode = 1;   // 0 low, 1 high, 2 random

  function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference: beats of one burst derived directly from the read rules.
  function automatic void push_burst(input logic [3:0] id, input logic [63:0] addr,
                                     input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic [63:0] start;
    logic [63:0] w;
    bit          bad;
    exp_t        e;
    start = addr >> 6;
    bad   = (size != 3'b110) || (burst == 2'b10) || (burst == 2'b11);
    for (int b = 0; b <= int'(len); b++) begin
      w      = (burst == 2'b01) ? start + 64'(b) : start;
      e.id   = id;
      e.last = (b == int'(len));
      if (bad) begin
        e.resp = 2'b10; e.data = '0;
      end else if (w >= 64'(DEPTH_WORDS)) begin
        e.resp = 2'b11; e.data = '0;
      end else begin
        e.resp = 2'b00; e.data = ref_mem[w[9:0]];
      end
      exp_q.push_back(e);
    end
  endfunction

  // rready driver
  always @(posedge axis_clk) begin
    #1;
    case (rready_mode)
      0:       s_axi_rready = 1'b0;
      1:       s_axi_rready = 1'b1;
      default: s_axi_rready = 1'($urandom_range(0, 1));
    endcase
  end

  // R monitor: compares every handshake against the scoreboard and checks that a
  // stalled beat holds still.
  logic         held_v = 1'b0;
  logic [3:0]   held_id;
  logic [1:0]   held_resp;
  logic         held_last;
  logic [511:0] held_data;
  exp_t         mon_e;

  always @(negedge axis_clk) begin
    if (axis_rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("r_hold_valid", 512'(s_axi_rvalid), 512'(1));
        chk("r_hold_ctl", 512'({s_axi_rid, s_axi_rresp, s_axi_rlast}),
            512'({held_id, held_resp, held_last}));
        chk("r_hold_data", s_axi_rdata, held_data);
      end
      held_v = 1'b0;
      if (s_axi_rvalid && s_axi_rready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected: actual rid=%0h resp=%0h required no beat", s_axi_rid, s_axi_rresp);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rid", 512'(s_axi_rid), 512'(mon_e.id));
          chk("rresp", 512'(s_axi_rresp), 512'(mon_e.resp));
          chk("rlast", 512'(s_axi_rlast), 512'(mon_e.last));
          chk("rdata", s_axi_rdata, mon_e.data);
          chk("burst_cnt_at_beat", 512'(burst_cnt), 512'(exp_bursts));
          if (mon_e.last) exp_bursts++;
        end
      end else if (s_axi_rvalid) begin
        held_v = 1'b1;
        held_id = s_axi_rid; held_resp = s_axi_rresp;
        held_last = s_axi_rlast; held_data = s_axi_rdata;
      end
    end
  end

  // Call at posedge+1. Returns at posedge+1 after the accepting edge.
  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bit ok = 1'b0;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    while (n < 3000) begin
      @(negedge axis_clk);
      if (s_axi_arready) begin
        @(posedge axis_clk); #1;
        ok = 1'b1;
        break;
      end
      n++;
    end
    s_axi_arvalid = 1'b0;
    if (ok) push_burst(id, addr, len, size, burst);
    else begin
      checks++; errors++;
      $display("FAIL ar_timeout: actual arready never high required accept id=%0h", id);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 5000) begin
      @(negedge axis_clk);
      if (exp_q.size() == 0 && !busy) break;
      n++;
    end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL %s_drain: actual %0d beats outstanding busy=%0b required 0", name, exp_q.size(), busy);
    end
    chk({name, "_burst_cnt"}, 512'(burst_cnt), 512'(exp_bursts));
    @(posedge axis_clk); #1;
  endtask

  initial begin
    int k;
    int acc;
    int low_run;
    logic [511:0] w;
    logic [63:0]  a;
    logic [2:0]   sz;
    logic [1:0]   bu;
    int           sel;

    // ---- reset values ----
    repeat (2) @(posedge axis_clk);
    @(negedge axis_clk);
    chk("rst_arready", 512'(s_axi_arready), 512'(0));
    chk("rst_rvalid", 512'(s_axi_rvalid), 512'(0));
    chk("rst_r_ctl", 512'({s_axi_rlast, s_axi_rresp, s_axi_rid}), 512'(0));
    chk("rst_rdata", s_axi_rdata, 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_burst_cnt", 512'(burst_cnt), 512'(0));
    @(posedge axis_clk); #1;
    axis_rst = 1'b0;

    // ---- backdoor preload ----
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      if (i < 4) w = 512'(8'hA0 + i);
      else for (int j = 0; j < 16; j++) w[j*32 +: 32] = $urandom;
      mem_wr_en = 1'b1; mem_wr_addr = 10'(i); mem_wr_data = w;
      ref_mem[i] = w;
      @(posedge axis_clk); #1;
    end
    mem_wr_en = 1'b0;

    // ---- INCR words 0..3, latency ----
    rready_mode = 1;
    send_ar(4'd1, 64'h0, 8'd3, 3'b110, 2'b01);
    k = 0;
    while (k < 20) begin
      @(posedge axis_clk); #1;
      k++;
      if (s_axi_rvalid) break;
    end
    chk("ar_to_rvalid_edges", 512'(k), 512'(3));
    wait_idle("incr4");

    // ---- FIXED on word 2 ----
    send_ar(4'd2, 64'h80, 8'd2, 3'b110, 2'b00);
    wait_idle("fixed3");

    // ---- top-of-memory crossing ----
    send_ar(4'd3, 64'hFFC0, 8'd1, 3'b110, 2'b01);
    wait_idle("top_edge");

    // ---- illegal size / burst ----
    send_ar(4'd4, 64'h40, 8'd0, 3'b101, 2'b01);
    send_ar(4'd5, 64'h40, 8'd0, 3'b110, 2'b10);
    wait_idle("illegal");

    // ---- backpressure: rready low, fill until arready stays low ----
    rready_mode = 0;
    acc = 0; low_run = 0;
    s_axi_arid = 4'd0; s_axi_araddr = 64'h0; s_axi_arlen = 8'd0;
    s_axi_arsize = 3'b110; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    for (int c = 0; c < 200 && low_run < 10; c++) begin
      @(negedge axis_clk);
      @(posedge axis_clk);
      if (s_axi_arready) begin
        #1;
        push_burst(4'(acc), 64'(acc) << 6, 8'd0, 3'b110, 2'b01);
        acc++; low_run = 0;
        s_axi_arid = 4'(acc); s_axi_araddr = 64'(acc) << 6;
      end else begin
        #1;
        low_run++;
      end
    end
    s_axi_arvalid = 1'b0;
    // The queue plus the engine and output buffer absorb a few requests.
    checks++;
    if (acc < AR_FIFO_DEPTH || acc > AR_FIFO_DEPTH + 4) begin
      errors++;
      $display("FAIL bp_accepted: actual %0d required %0d..%0d", acc, AR_FIFO_DEPTH, AR_FIFO_DEPTH + 4);
    end
    chk("bp_arready_held_low", 512'(low_run), 512'(10));
    chk("bp_busy", 512'(busy), 512'(1));
    rready_mode = 1;
    wait_idle("bp");

    // ---- reset on beat 2 of an 8-beat burst ----
    send_ar(4'd9, 64'h1000, 8'd7, 3'b110, 2'b01);
    repeat (5) @(posedge axis_clk);
    #1 axis_rst = 1'b1;
    @(posedge axis_clk); #1;
    axis_rst = 1'b0;
    exp_q.delete();
    exp_bursts = 0;
    @(negedge axis_clk);
    chk("midrst_rvalid", 512'(s_axi_rvalid), 512'(0));
    chk("midrst_burst_cnt", 512'(burst_cnt), 512'(0));
    chk("midrst_busy", 512'(busy), 512'(0));
    @(posedge axis_clk); #1;
    send_ar(4'd6, 64'h2345, 8'd4, 3'b110, 2'b01);
    wait_idle("post_rst");

    // ---- randomized traffic ----
    rready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)
        a = {$urandom, $urandom};
      else if (sel == 1)
        a = (64'($urandom_range(1010, 1023)) << 6) | 64'($urandom_range(0, 63));
      else
        a = (64'($urandom_range(0, 1023)) << 6) | 64'($urandom_range(0, 63));
      sz = (sel == 2) ? 3'($urandom_range(0, 7)) : 3'b110;
      bu = (sel == 3) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
      send_ar(4'($urandom_range(0, 15)), a, 8'($urandom_range(0, 15)), sz, bu);
    end
    wait_idle("random");

    chk("scoreboard_empty", 512'(exp_q.size()), 512'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual simulation still running required finish");
    $fatal(1, "timeout");
  end

endmodule
